slave_session_ctrl: RTL and testbench

Per-slave session controller placed directly downstream of each slave's round-robin arbiter inside the cross bar. It consumes the arbiter's one-hot grant and latches the winning master's transaction. It drives that transaction onto the slave port and routes the slave's acceptance and response back to the winning master. It then pulses `session_is_finished` so the arbiter can rotate priority.

---
 rtl/interface_connection.sv | 17 +
 rtl/onehot_to_index.sv | 24 ++
 rtl/slave_session_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_slave_session_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interface_connection.sv
// Shared cross-bar definitions: bus widths, the session FSM state type and
// the command encoding used on every master and slave port.
package interface_connection;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_RESP = 2'd2
    } session_state_t;

endpackage

// File: rtl/onehot_to_index.sv
// Converts a (nominally one-hot) grant vector into a binary index.
// With several bits set, the lowest set bit wins; valid flags a non-zero input.
module onehot_to_index #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] index,
    output logic             valid
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        index = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (onehot[i]) begin
                index = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/slave_session_ctrl.sv
// Per-slave session controller: latches the arbiter's winner, drives the slave
// port and routes ack/response back. Optional abort timer: SLAVE_TIMEOUT_EN.
module slave_session_ctrl
    import interface_connection::*;
#(
    parameter int N_MASTERS  = 4,
    parameter int ADDR_WIDTH = interface_connection::ADDR_WIDTH,
    parameter int DATA_WIDTH = interface_connection::DATA_WIDTH,
    parameter int TIMEOUT    = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_MASTERS-1:0]             grant,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]  m_addr,
    input  logic [N_MASTERS-1:0]             m_cmd,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]  m_wdata,
    output logic [N_MASTERS-1:0]             m_ack,
    output logic [N_MASTERS-1:0]             m_resp,
    output logic [DATA_WIDTH-1:0]            m_rdata,
    output logic                             m_err,
    output logic                             s_req,
    output logic [ADDR_WIDTH-1:0]            s_addr,
    output logic                             s_cmd,
    output logic [DATA_WIDTH-1:0]            s_wdata,
    input  logic                             s_ack,
    input  logic                             s_resp,
    input  logic [DATA_WIDTH-1:0]            s_rdata,
    output logic                             session_is_finished
);

    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    session_state_t          state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    cmd_q, cmd_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    s_req_q, s_req_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    resp_pulse_q, resp_pulse_d;

    logic [IDX_W-1:0]        grant_idx;
    logic                    grant_valid;
    logic [N_MASTERS-1:0]    sel_onehot;
    logic                    ack_fire;

`ifdef SLAVE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    timeout_hit;

    assign timeout_hit = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT));
    assign ack_fire    = (state_q == SEND) && s_ack && !timeout_hit;
    assign m_err       = err_q;
`else
    assign ack_fire    = (state_q == SEND) && s_ack;
    assign m_err       = 1'b0;
`endif

    onehot_to_index #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_grant_idx (
        .onehot (grant),
        .index  (grant_idx),
        .valid  (grant_valid)
    );

    assign sel_onehot          = N_MASTERS'(1) << idx_q;
    assign m_ack               = ack_fire ? sel_onehot : '0;
    assign m_resp              = resp_pulse_q ? sel_onehot : '0;
    assign m_rdata             = rdata_q;
    assign s_req               = s_req_q;
    assign s_addr              = addr_q;
    assign s_cmd               = cmd_q;
    assign s_wdata             = wdata_q;
    assign session_is_finished = resp_pulse_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
        cmd_d        = cmd_q;
        wdata_d      = wdata_q;
        s_req_d      = s_req_q;
        rdata_d      = rdata_q;
        resp_pulse_d = 1'b0;
`ifdef SLAVE_TIMEOUT_EN
        err_d        = 1'b0;
        cnt_d        = cnt_q;
        if (state_q != IDLE) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
`endif

        unique case (state_q)
            IDLE: begin
                // Master fields are captured once here; later grant changes are ignored.
                if (grant_valid) begin
                    idx_d   = grant_idx;
                    addr_d  = m_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    cmd_d   = m_cmd[grant_idx];
                    wdata_d = m_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                    s_req_d = 1'b1;
                    state_d = SEND;
`ifdef SLAVE_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end

            SEND: begin
`ifdef SLAVE_TIMEOUT_EN
                if (timeout_hit) begin
                    s_req_d      = 1'b0;
                    rdata_d      = '0;
                    err_d        = 1'b1;
                    resp_pulse_d = 1'b1;
                    state_d      = IDLE;
                end else
`endif
                if (s_ack) begin
                    s_req_d = 1'b0;
                    state_d = WAIT_RESP;
                end
            end

            WAIT_RESP: begin
                // A real response beats a simultaneous timeout.
                if (s_resp) begin
                    rdata_d      = s_rdata;
                    resp_pulse_d = 1'b1;
                    state_d      = IDLE;
                end
`ifdef SLAVE_TIMEOUT_EN
                else if (timeout_hit) begin
                    rdata_d      = '0;
                    err_d        = 1'b1;
                    resp_pulse_d = 1'b1;
                    state_d      = IDLE;
                end
`endif
            end

            default: begin
                s_req_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            addr_q       <= '0;
            cmd_q        <= 1'b0;
            wdata_q      <= '0;
            s_req_q      <= 1'b0;
            rdata_q      <= '0;
            resp_pulse_q <= 1'b0;
`ifdef SLAVE_TIMEOUT_EN
            cnt_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            cmd_q        <= cmd_d;
            wdata_q      <= wdata_d;
            s_req_q      <= s_req_d;
            rdata_q      <= rdata_d;
            resp_pulse_q <= resp_pulse_d;
`ifdef SLAVE_TIMEOUT_EN
            cnt_q        <= cnt_d;
            err_q        <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_slave_session_ctrl.sv
// Directed bench for slave_session_ctrl: a table of sessions run back to back,
// then hand-written grant-change, reset and (SLAVE_TIMEOUT_EN) timeout sequences.
module tb_slave_session_ctrl;

    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic               clk;
    logic               rst_n;
    logic [NM-1:0]      grant;
    logic [NM*AW-1:0]   m_addr;
    logic [NM-1:0]      m_cmd;
    logic [NM*DW-1:0]   m_wdata;
    logic [NM-1:0]      m_ack;
    logic [NM-1:0]      m_resp;
    logic [DW-1:0]      m_rdata;
    logic               m_err;
    logic               s_req;
    logic [AW-1:0]      s_addr;
    logic               s_cmd;
    logic [DW-1:0]      s_wdata;
    logic               s_ack;
    logic               s_resp;
    logic [DW-1:0]      s_rdata;
    logic               session_is_finished;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [NM-1:0] grant;
        int            exp_idx;
        logic          cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            ack_delay;
        int            resp_delay;
        bit            noise;
    } vec_t;

    vec_t vecs[5];

    slave_session_ctrl #(
        .N_MASTERS  (NM),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (16)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .grant               (grant),
        .m_addr              (m_addr),
        .m_cmd               (m_cmd),
        .m_wdata             (m_wdata),
        .m_ack               (m_ack),
        .m_resp              (m_resp),
        .m_rdata             (m_rdata),
        .m_err               (m_err),
        .s_req               (s_req),
        .s_addr              (s_addr),
        .s_cmd               (s_cmd),
        .s_wdata             (s_wdata),
        .s_ack               (s_ack),
        .s_resp              (s_resp),
        .s_rdata             (s_rdata),
        .session_is_finished (session_is_finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [NM-1:0] oh(input int i);
        return NM'(1) << i;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Granted master gets the real fields; every other master carries decoys.
    task automatic apply_stimulus(input int idx, input logic [AW-1:0] addr,
                                  input logic cmd, input logic [DW-1:0] wdata);
        for (int m = 0; m < NM; m++) begin
            if (m == idx) begin
                m_addr[m*AW +: AW]  = addr;
                m_cmd[m]            = cmd;
                m_wdata[m*DW +: DW] = wdata;
            end else begin
                m_addr[m*AW +: AW]  = 32'hBAD0_0000 | 32'(m);
                m_cmd[m]            = ~cmd;
                m_wdata[m*DW +: DW] = 32'hFFFF_0000 | 32'(m);
            end
        end
    endtask

    // Starts in a cycle where the FSM is IDLE and ends in the finished-pulse cycle.
    task automatic run_vec(input vec_t v);
        apply_stimulus(v.exp_idx, v.addr, v.cmd, v.wdata);
        grant = v.grant;
        #1;
        check_output("idle s_req", 64'(s_req), 64'(0));
        step();
        grant = '0;
        #1;
        check_output("send s_req", 64'(s_req), 64'(1));
        check_output("send s_addr", 64'(s_addr), 64'(v.addr));
        check_output("send s_cmd", 64'(s_cmd), 64'(v.cmd));
        check_output("send s_wdata", 64'(s_wdata), 64'(v.wdata));
        check_output("send finished", 64'(session_is_finished), 64'(0));
        for (int c = 0; c < v.ack_delay; c++) begin
            s_resp = v.noise;
            #1;
            check_output("send wait m_ack", 64'(m_ack), 64'(0));
            step();
            s_resp = 1'b0;
            #1;
            check_output("send hold s_req", 64'(s_req), 64'(1));
        end
        s_ack = 1'b1;
        #1;
        check_output("m_ack", 64'(m_ack), 64'(oh(v.exp_idx)));
        step();
        s_ack = 1'b0;
        #1;
        check_output("wait s_req", 64'(s_req), 64'(0));
        for (int c = 0; c < v.resp_delay; c++) begin
            s_ack = v.noise;
            #1;
            check_output("wait m_ack", 64'(m_ack), 64'(0));
            check_output("wait m_resp", 64'(m_resp), 64'(0));
            step();
            s_ack = 1'b0;
        end
        s_resp  = 1'b1;
        s_rdata = v.rdata;
        #1;
        check_output("resp cycle m_resp", 64'(m_resp), 64'(0));
        step();
        s_resp  = 1'b0;
        s_rdata = 32'h0BAD_F00D;
        #1;
        check_output("m_resp", 64'(m_resp), 64'(oh(v.exp_idx)));
        check_output("m_rdata", 64'(m_rdata), 64'(v.rdata));
        check_output("m_err", 64'(m_err), 64'(0));
        check_output("finished", 64'(session_is_finished), 64'(1));
        check_output("pulse m_ack", 64'(m_ack), 64'(0));
    endtask

    initial begin
        vecs[0] = '{4'b0010, 1, 1'b0, 32'h4000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 0, 0, 1'b0};
        vecs[1] = '{4'b0001, 0, 1'b1, 32'h1000_0000, 32'h0000_0001, 32'h0000_00AA, 1, 0, 1'b0};
        vecs[2] = '{4'b1000, 3, 1'b1, 32'h3000_0000, 32'h0000_0003, 32'h5555_AAAA, 0, 2, 1'b1};
        vecs[3] = '{4'b1100, 2, 1'b0, 32'h2000_0040, 32'h0000_0000, 32'h1234_5678, 2, 1, 1'b1};
        vecs[4] = '{4'b0111, 0, 1'b0, 32'h0000_0004, 32'h0000_0000, 32'hCAFE_F00D, 0, 0, 1'b0};

        rst_n   = 1'b1;
        grant   = '0;
        m_addr  = '0;
        m_cmd   = '0;
        m_wdata = '0;
        s_ack   = 1'b0;
        s_resp  = 1'b0;
        s_rdata = '0;
        #1 rst_n = 1'b0;
        #1;
        check_output("reset s_req", 64'(s_req), 64'(0));
        check_output("reset s_addr", 64'(s_addr), 64'(0));
        check_output("reset s_cmd", 64'(s_cmd), 64'(0));
        check_output("reset s_wdata", 64'(s_wdata), 64'(0));
        check_output("reset m_ack", 64'(m_ack), 64'(0));
        check_output("reset m_resp", 64'(m_resp), 64'(0));
        check_output("reset m_rdata", 64'(m_rdata), 64'(0));
        check_output("reset m_err", 64'(m_err), 64'(0));
        check_output("reset finished", 64'(session_is_finished), 64'(0));
        step();
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
        end
        grant = '0;
        step();
        #1;
        check_output("after pulse m_resp", 64'(m_resp), 64'(0));
        check_output("after pulse finished", 64'(session_is_finished), 64'(0));

        // Grant moves to master 2 during the session; master 0 keeps it.
        apply_stimulus(0, 32'hA000_0000, 1'b0, 32'h0);
        m_addr[2*AW +: AW] = 32'hA200_0000;
        grant = 4'b0001;
        step();
        grant = 4'b0100;
        #1;
        check_output("chg send s_addr", 64'(s_addr), 64'(32'hA000_0000));
        s_ack = 1'b1;
        #1;
        check_output("chg m_ack", 64'(m_ack), 64'(4'b0001));
        step();
        s_ack = 1'b0;
        step();
        #1;
        check_output("chg wait s_addr", 64'(s_addr), 64'(32'hA000_0000));
        s_resp  = 1'b1;
        s_rdata = 32'h0000_5A5A;
        grant   = '0;
        step();
        s_resp = 1'b0;
        #1;
        check_output("chg m_resp", 64'(m_resp), 64'(4'b0001));
        check_output("chg m_rdata", 64'(m_rdata), 64'(32'h0000_5A5A));
        step();
        #1;
        check_output("chg idle s_req", 64'(s_req), 64'(0));

        // Reset while waiting for a response that is already being offered.
        apply_stimulus(3, 32'hB300_0000, 1'b1, 32'h33);
        grant = 4'b1000;
        step();
        grant = '0;
        s_ack = 1'b1;
        step();
        s_ack  = 1'b0;
        s_resp = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_output("rst s_req", 64'(s_req), 64'(0));
        check_output("rst m_resp", 64'(m_resp), 64'(0));
        check_output("rst s_addr", 64'(s_addr), 64'(0));
        step();
        #1;
        check_output("rst held m_resp", 64'(m_resp), 64'(0));
        check_output("rst held finished", 64'(session_is_finished), 64'(0));
        check_output("rst held m_rdata", 64'(m_rdata), 64'(0));
        rst_n = 1'b1;
        step();
        s_resp = 1'b0;
        #1;
        check_output("post rst m_resp", 64'(m_resp), 64'(0));
        check_output("post rst s_req", 64'(s_req), 64'(0));
        apply_stimulus(2, 32'hC200_0000, 1'b0, 32'h0);
        grant = 4'b0100;
        step();
        grant = '0;
        #1;
        check_output("post rst send s_req", 64'(s_req), 64'(1));
        check_output("post rst s_addr", 64'(s_addr), 64'(32'hC200_0000));
        s_ack = 1'b1;
        step();
        s_ack   = 1'b0;
        s_resp  = 1'b1;
        s_rdata = 32'h0000_00C2;
        step();
        s_resp = 1'b0;
        #1;
        check_output("post rst m_resp", 64'(m_resp), 64'(4'b0100));
        check_output("post rst m_rdata", 64'(m_rdata), 64'(32'h0000_00C2));

        // Silent slave: SEND entry is cycle 0, ack arrives in cycle 2.
        apply_stimulus(1, 32'hD100_0000, 1'b0, 32'h0);
        grant = 4'b0010;
        step();
        grant = '0;
`ifdef SLAVE_TIMEOUT_EN
        for (int c = 0; c <= 16; c++) begin
            s_ack = (c == 2);
            #1;
            check_output("to s_req", 64'(s_req), 64'(c <= 2));
            check_output("to m_ack", 64'(m_ack), 64'((c == 2) ? 4'b0010 : 4'b0000));
            check_output("to early m_resp", 64'(m_resp), 64'(0));
            step();
            s_ack = 1'b0;
        end
        #1;
        check_output("to m_resp", 64'(m_resp), 64'(4'b0010));
        check_output("to m_err", 64'(m_err), 64'(1));
        check_output("to m_rdata", 64'(m_rdata), 64'(0));
        check_output("to finished", 64'(session_is_finished), 64'(1));
        check_output("to s_req", 64'(s_req), 64'(0));
        step();
        #1;
        check_output("to after m_err", 64'(m_err), 64'(0));
        check_output("to after finished", 64'(session_is_finished), 64'(0));
`else
        for (int c = 0; c < 30; c++) begin
            s_ack = (c == 2);
            #1;
            check_output("nto m_resp", 64'(m_resp), 64'(0));
            step();
            s_ack = 1'b0;
        end
        s_resp  = 1'b1;
        s_rdata = 32'h0000_D1D1;
        step();
        s_resp = 1'b0;
        #1;
        check_output("nto m_resp", 64'(m_resp), 64'(4'b0010));
        check_output("nto m_err", 64'(m_err), 64'(0));
        check_output("nto m_rdata", 64'(m_rdata), 64'(32'h0000_D1D1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
